// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: memory-control bit positions, MEM-stage FSM
// states and the byte-swap helper also used by the instruction fetch stage.
package riscv_pkg;

   localparam int MEM_READ_BIT  = 1;
   localparam int MEM_WRITE_BIT = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mem_state_e;

   // The cache orders bytes little-endian while the core's word order is big-endian.
   function automatic logic [31:0] byte_swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-cache request/response port between the MEM stage (master) and the cache (slave).
interface mem_access_stage_if;

   logic        DCACHE_ren;
   logic        DCACHE_wen;
   logic [29:0] DCACHE_addr;
   logic [31:0] DCACHE_wdata;
   logic        DCACHE_stall;
   logic [31:0] DCACHE_rdata;

   modport master (
      output DCACHE_ren,
      output DCACHE_wen,
      output DCACHE_addr,
      output DCACHE_wdata,
      input  DCACHE_stall,
      input  DCACHE_rdata
   );

   modport slave (
      input  DCACHE_ren,
      input  DCACHE_wen,
      input  DCACHE_addr,
      input  DCACHE_wdata,
      output DCACHE_stall,
      output DCACHE_rdata
   );

endinterface

// File: rtl/mem_access_stage_stall_counter.sv
// Saturating performance counter of cycles in which the MEM stage stalls the pipe.
module mem_stall_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage RV32 core: data-cache load/store handshake,
// pipeline stall generation and the MEM/WB register.
module mem_access_stage
   import riscv_pkg::*;
#(
   parameter bit SWAP_ENDIAN = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      WriteBack_3,
   input  logic [1:0]                Mem_3,
   input  logic [31:0]               ALU_result_3,
   input  logic [31:0]               writedata_3,
   input  logic [4:0]                Rd_3,
   mem_access_stage_if.master        dcache,
   output logic                      memory_stall,
   output logic                      WriteBack_4,
   output logic [4:0]                Rd_4,
   output logic [31:0]               writeback_data_4,
   output logic [CNT_W-1:0]          stall_cycles
);

   logic        op;
   logic        is_load;
   logic        is_store;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic [31:0] wb_sel;

   mem_state_e  state;
   mem_state_e  state_next;

   // Illegal 2'b11 decodes as a read because only the read bit is tested for loads.
   assign op       = (|Mem_3) & ~rst;
   assign is_load  = Mem_3[MEM_READ_BIT];
   assign is_store = Mem_3[MEM_WRITE_BIT] & ~Mem_3[MEM_READ_BIT];

   assign store_data = SWAP_ENDIAN ? byte_swap(writedata_3) : writedata_3;
   assign load_data  = SWAP_ENDIAN ? byte_swap(dcache.DCACHE_rdata) : dcache.DCACHE_rdata;

   assign dcache.DCACHE_ren   = op & is_load;
   assign dcache.DCACHE_wen   = op & is_store;
   assign dcache.DCACHE_addr  = op ? ALU_result_3[31:2] : 30'd0;
   assign dcache.DCACHE_wdata = op ? store_data : 32'd0;

   assign memory_stall = op & dcache.DCACHE_stall;

   assign wb_sel = is_load ? load_data : ALU_result_3;

   // Stage 3 stays frozen while stalled, so BUSY needs no copy of the request.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (op && dcache.DCACHE_stall) state_next = S_BUSY;
         S_BUSY: if (!op || !dcache.DCACHE_stall) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // MEM/WB boundary: hold while the cache is busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         WriteBack_4      <= 1'b0;
         Rd_4             <= 5'd0;
         writeback_data_4 <= 32'd0;
      end else if (!memory_stall) begin
         WriteBack_4      <= WriteBack_3;
         Rd_4             <= Rd_3;
         writeback_data_4 <= wb_sel;
      end
   end

   mem_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (memory_stall),
      .count (stall_cycles)
   );

endmodule
